// File: rtl/init_mon_reset_sequencer.sv
// init_mon_reset_sequencer
// Brings FABRIC_POR_N, DEVICE_INIT_DONE and the per-bank calibration status
// into SCLK. The combined status must hold for a run of cycles before the
// block releases a staggered set of active-low fabric resets. A watchdog
// forces a terminal TIMEOUT if the release does not finish in time.
// Build option: define INIT_MON_RECALIB_MONITOR_EN to watch for loss of
// calibration in READY. That option also adds the sticky RECALIB_EVENT output.
module init_mon_reset_sequencer #(
    parameter int NUM_BANKS      = 4,
    parameter int NUM_RESETS     = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  SCLK,
    input  logic                  RESETN,
    input  logic                  FABRIC_POR_N,
    input  logic                  DEVICE_INIT_DONE,
    input  logic [NUM_BANKS-1:0]  BANK_CALIB_STATUS,
    input  logic [NUM_BANKS-1:0]  BANK_MASK,
    output logic [NUM_RESETS-1:0] RESETN_OUT,
    output logic                  CALIB_DONE,
    output logic                  INIT_TIMEOUT,
    output logic [NUM_BANKS-1:0]  CALIB_STATUS_SYNC,
    output logic [2:0]            STATE
`ifdef INIT_MON_RECALIB_MONITOR_EN
    ,
    output logic                  RECALIB_EVENT
`endif
);

    localparam int SW = NUM_BANKS + 2;
    localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] STG_LAST  = 16'((NUM_RESETS - 1) * STAGGER_CYCLES);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] TO_MAX    = 24'hFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_STAGGER    = 3'd3,
        ST_READY      = 3'd4,
        ST_TIMEOUT    = 3'd5
    } state_e;

    // Synchroniser chain: bit 0 = POR, bit 1 = init done, upper bits = banks.
    logic [SW-1:0] async_in;
    logic [SW-1:0] sync_q [SYNC_STAGES];

    logic                 por_s;
    logic                 init_s;
    logic [NUM_BANKS-1:0] cal_s;
    logic                 qual;

    state_e               state_q, state_d;
    logic [15:0]          stab_cnt_q, stab_cnt_d;
    logic [15:0]          stg_cnt_q, stg_cnt_d;
    logic [15:0]          stg_inc;
    logic [23:0]          to_cnt_q, to_cnt_d;
    logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
    logic [NUM_RESETS-1:0] rel_mask;
    logic                 calib_done_q, calib_done_d;
    logic                 init_timeout_q, init_timeout_d;
    logic                 to_counting;
    logic                 to_expired;
`ifdef INIT_MON_RECALIB_MONITOR_EN
    logic                 recalib_q, recalib_d;
`endif

    assign async_in = {BANK_CALIB_STATUS, DEVICE_INIT_DONE, FABRIC_POR_N};

    // Multi-flop synchroniser for every asynchronous status input.
    always_ff @(posedge SCLK) begin
        if (!RESETN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign por_s  = sync_q[SYNC_STAGES-1][0];
    assign init_s = sync_q[SYNC_STAGES-1][1];
    assign cal_s  = sync_q[SYNC_STAGES-1][SW-1:2];

    // Masked banks are treated as calibrated.
    assign qual = por_s & init_s & (&(cal_s | BANK_MASK));

    assign to_counting = (state_q == ST_WAIT_INIT) || (state_q == ST_WAIT_CALIB) ||
                         (state_q == ST_STAGGER);
    assign to_expired  = to_counting && (to_cnt_q == TO_LAST);

    // Reset bit k is released once k*STAGGER_CYCLES cycles have elapsed in STAGGER.
    assign stg_inc = stg_cnt_q + 16'd1;
    for (genvar gi = 0; gi < NUM_RESETS; gi++) begin : g_release
        assign rel_mask[gi] = (stg_inc >= 16'(gi * STAGGER_CYCLES));
    end

    // Next-state and registered-output logic; POR loss beats timeout, which beats everything else.
    always_comb begin
        state_d        = state_q;
        stab_cnt_d     = stab_cnt_q;
        stg_cnt_d      = stg_cnt_q;
        to_cnt_d       = to_cnt_q;
        rst_out_d      = rst_out_q;
        calib_done_d   = 1'b0;
        init_timeout_d = 1'b0;
`ifdef INIT_MON_RECALIB_MONITOR_EN
        recalib_d      = recalib_q;
`endif
        if (to_counting && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + 24'd1;
        end

        if ((state_q != ST_IDLE) && !por_s) begin
            state_d    = ST_IDLE;
            stab_cnt_d = '0;
            stg_cnt_d  = '0;
            to_cnt_d   = '0;
            rst_out_d  = '0;
        end else if (to_expired) begin
            state_d        = ST_TIMEOUT;
            stab_cnt_d     = '0;
            stg_cnt_d      = '0;
            rst_out_d      = '0;
            init_timeout_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    to_cnt_d   = '0;
                    stab_cnt_d = '0;
                    stg_cnt_d  = '0;
                    rst_out_d  = '0;
                    if (por_s) begin
                        state_d = ST_WAIT_INIT;
                    end
                end
                ST_WAIT_INIT: begin
                    rst_out_d = '0;
                    if (init_s) begin
                        state_d = ST_WAIT_CALIB;
                    end
                end
                ST_WAIT_CALIB: begin
                    rst_out_d = '0;
                    if (qual) begin
                        if (stab_cnt_q == STAB_LAST) begin
                            state_d      = ST_STAGGER;
                            stab_cnt_d   = '0;
                            stg_cnt_d    = '0;
                            rst_out_d[0] = 1'b1;
                        end else begin
                            stab_cnt_d = stab_cnt_q + 16'd1;
                        end
                    end else begin
                        stab_cnt_d = '0;
                    end
                end
                ST_STAGGER: begin
                    if (!qual) begin
                        state_d    = ST_WAIT_CALIB;
                        stab_cnt_d = '0;
                        stg_cnt_d  = '0;
                        rst_out_d  = '0;
                    end else if (stg_cnt_q == STG_LAST) begin
                        state_d      = ST_READY;
                        stg_cnt_d    = '0;
                        rst_out_d    = '1;
                        calib_done_d = 1'b1;
                    end else begin
                        stg_cnt_d = stg_inc;
                        rst_out_d = rel_mask;
                    end
                end
                ST_READY: begin
                    rst_out_d    = '1;
                    calib_done_d = 1'b1;
`ifdef INIT_MON_RECALIB_MONITOR_EN
                    // In READY the stability counter measures how long qual has been lost.
                    if (!qual) begin
                        if (stab_cnt_q == STAB_LAST) begin
                            state_d      = ST_WAIT_CALIB;
                            stab_cnt_d   = '0;
                            to_cnt_d     = '0;
                            rst_out_d    = '0;
                            calib_done_d = 1'b0;
                            recalib_d    = 1'b1;
                        end else begin
                            stab_cnt_d = stab_cnt_q + 16'd1;
                        end
                    end else begin
                        stab_cnt_d = '0;
                    end
`endif
                end
                ST_TIMEOUT: begin
                    rst_out_d      = '0;
                    init_timeout_d = 1'b1;
                end
                default: begin
                    state_d   = ST_IDLE;
                    rst_out_d = '0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge SCLK) begin
        if (!RESETN) begin
            state_q        <= ST_IDLE;
            stab_cnt_q     <= '0;
            stg_cnt_q      <= '0;
            to_cnt_q       <= '0;
            rst_out_q      <= '0;
            calib_done_q   <= 1'b0;
            init_timeout_q <= 1'b0;
`ifdef INIT_MON_RECALIB_MONITOR_EN
            recalib_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            stab_cnt_q     <= stab_cnt_d;
            stg_cnt_q      <= stg_cnt_d;
            to_cnt_q       <= to_cnt_d;
            rst_out_q      <= rst_out_d;
            calib_done_q   <= calib_done_d;
            init_timeout_q <= init_timeout_d;
`ifdef INIT_MON_RECALIB_MONITOR_EN
            recalib_q      <= recalib_d;
`endif
        end
    end

    assign RESETN_OUT        = rst_out_q;
    assign CALIB_DONE        = calib_done_q;
    assign INIT_TIMEOUT      = init_timeout_q;
    assign CALIB_STATUS_SYNC = cal_s;
    assign STATE             = state_q;
`ifdef INIT_MON_RECALIB_MONITOR_EN
    assign RECALIB_EVENT     = recalib_q;
`endif

endmodule

// File: tb/tb_init_mon_reset_sequencer.sv
// Self-checking bench for init_mon_reset_sequencer.
// The reference model tracks the qualification process with event timestamps.
// Each expected output is derived from the time elapsed since those events.
module tb_init_mon_reset_sequencer;

    localparam int NB  = 4;
    localparam int NR  = 3;
    localparam int SS  = 2;
    localparam int STB = 16;
    localparam int STG = 8;
    localparam int TO  = 200;
    localparam int VW  = 6 + NR + NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          por;
    logic          init;
    logic [NB-1:0] cal;
    logic [NB-1:0] mask;
    logic [NR-1:0] rout;
    logic          cdone;
    logic          tmo;
    logic [NB-1:0] csync;
    logic [2:0]    st;
`ifdef INIT_MON_RECALIB_MONITOR_EN
    logic          recal;
`endif

    init_mon_reset_sequencer #(
        .NUM_BANKS(NB), .NUM_RESETS(NR), .SYNC_STAGES(SS),
        .STABLE_CYCLES(STB), .STAGGER_CYCLES(STG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .SCLK(clk),
        .RESETN(rstn),
        .FABRIC_POR_N(por),
        .DEVICE_INIT_DONE(init),
        .BANK_CALIB_STATUS(cal),
        .BANK_MASK(mask),
        .RESETN_OUT(rout),
        .CALIB_DONE(cdone),
        .INIT_TIMEOUT(tmo),
        .CALIB_STATUS_SYNC(csync),
        .STATE(st)
`ifdef INIT_MON_RECALIB_MONITOR_EN
        ,
        .RECALIB_EVENT(recal)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Raw input history indexed by the clock edge that sampled it.
    logic          h_por  [64];
    logic          h_init [64];
    logic [NB-1:0] h_cal  [64];
    int            last_rst = 0;

    // Reference model: phase plus timestamps of the events that matter.
    int ms        = 0;
    int e_init    = 0;
    int e_stg     = 0;
    int q_since   = -1;
    int low_since = -1;
    logic m_recal = 1'b0;

    logic [NR-1:0] exp_rout;
    logic          exp_cdone;
    logic          exp_tmo;
    logic [NB-1:0] exp_sync;
    logic [2:0]    exp_st;

    task automatic model_step(input int m);
        logic          ps;
        logic          is_;
        logic          q;
        logic [NB-1:0] cs;
        if (!rstn) begin
            ms = 0; last_rst = m; m_recal = 1'b0; q_since = -1; low_since = -1;
        end else begin
            if (m - SS > last_rst) begin
                ps = h_por[(m-SS)%64]; is_ = h_init[(m-SS)%64]; cs = h_cal[(m-SS)%64];
            end else begin
                ps = 1'b0; is_ = 1'b0; cs = '0;
            end
            q = ps && is_ && ((cs | mask) == {NB{1'b1}});
            if (ms != 0 && !ps) begin
                ms = 0;
            end else if ((ms == 1 || ms == 2 || ms == 3) && (m - e_init >= TO)) begin
                ms = 5;
            end else begin
                case (ms)
                    0: if (ps) begin ms = 1; e_init = m; end
                    1: if (is_) begin ms = 2; q_since = -1; end
                    2: begin
                        if (q) begin
                            if (q_since < 0) q_since = m;
                            if (m - q_since + 1 >= STB) begin ms = 3; e_stg = m; end
                        end else begin
                            q_since = -1;
                        end
                    end
                    3: begin
                        if (!q) begin ms = 2; q_since = -1; end
                        else if (m - e_stg - 1 >= (NR-1)*STG) begin ms = 4; low_since = -1; end
                    end
                    4: begin
`ifdef INIT_MON_RECALIB_MONITOR_EN
                        if (!q) begin
                            if (low_since < 0) low_since = m;
                            if (m - low_since + 1 >= STB) begin
                                ms = 2; q_since = -1; e_init = m; m_recal = 1'b1;
                            end
                        end else begin
                            low_since = -1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
        exp_st    = 3'(ms);
        exp_cdone = (ms == 4);
        exp_tmo   = (ms == 5);
        for (int k = 0; k < NR; k++) begin
            exp_rout[k] = (ms == 4) || ((ms == 3) && ((m - e_stg) >= k*STG));
        end
        exp_sync = (m - SS + 1 > last_rst) ? h_cal[(m-SS+1)%64] : '0;
    endtask

    // Advance one clock: log inputs, step the model, return at the falling edge.
    task automatic tick();
        cyc++;
        h_por[cyc%64]  = por;
        h_init[cyc%64] = init;
        h_cal[cyc%64]  = cal;
        model_step(cyc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        logic r;
        r = 1'b0;
`ifdef INIT_MON_RECALIB_MONITOR_EN
        r = recal;
`endif
        return {r, st, tmo, cdone, rout, csync};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_recal, exp_st, exp_tmo, exp_cdone, exp_rout, exp_sync};
    endfunction

    task automatic test_reset();
        rstn = 1'b0; mask = '0;
        for (int i = 0; i < 4; i++) begin
            por = 1'($urandom); init = 1'($urandom); cal = NB'($urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (st !== 3'd0 || rout !== '0 || cdone !== 1'b0 || tmo !== 1'b0 || csync !== '0) begin
            failures++;
            $display("FAIL reset_values got st=%0d rout=%b cdone=%b tmo=%b sync=%b exp all 0",
                     st, rout, cdone, tmo, csync);
        end
        rstn = 1'b1;
    endtask

    task automatic test_nominal();
        int tp, ti, tmax, base, pe, ie, wc, qe, start;
        int tc [NB];
        int r1, r2, r3, rd;
        por = 0; init = 0; cal = '0; mask = '0;
        do_reset();
        base = cyc;
        tp = $urandom_range(0, 10); ti = $urandom_range(0, 10);
        tmax = (tp > ti) ? tp : ti;
        for (int b = 0; b < NB; b++) begin
            tc[b] = $urandom_range(0, 10);
            if (tc[b] > tmax) tmax = tc[b];
        end
        r1 = -1; r2 = -1; r3 = -1; rd = -1;
        for (int i = 0; i < 70; i++) begin
            por = (i >= tp); init = (i >= ti);
            for (int b = 0; b < NB; b++) cal[b] = (i >= tc[b]);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL nominal_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (r1 < 0 && rout === 3'b001) r1 = cyc;
            if (r2 < 0 && rout === 3'b011) r2 = cyc;
            if (r3 < 0 && rout === 3'b111) r3 = cyc;
            if (rd < 0 && cdone === 1'b1) rd = cyc;
        end
        pe = base + tp + 1 + SS;
        ie = base + ti + 1 + SS;
        wc = (pe + 1 > ie) ? pe + 1 : ie;
        qe = base + tmax + 1 + SS;
        start = (wc + 1 > qe) ? wc + 1 : qe;
        checks++;
        if (r1 != start + STB - 1) begin
            failures++;
            $display("FAIL nominal_bit0_time got=%0d exp=%0d", r1, start + STB - 1);
        end
        checks++;
        if (r2 - r1 != STG || r3 - r2 != STG) begin
            failures++;
            $display("FAIL nominal_spacing got=%0d,%0d exp=%0d", r2 - r1, r3 - r2, STG);
        end
        checks++;
        if (rd - r3 != 1) begin
            failures++;
            $display("FAIL nominal_done_time got=%0d exp=1", rd - r3);
        end
    endtask

    task automatic test_glitch();
        int k, rec, r1;
        por = 1; init = 1; cal = '1; mask = '0;
        do_reset();
        k = $urandom_range(6, 14);
        for (int i = 0; i < k + 50; i++) begin
            if (i == k) cal[2] = 1'b0;
            if (i == k + 5) begin cal[2] = 1'b1; rec = cyc + 1; r1 = -1; end
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (i >= k + 5 && r1 < 0 && rout === 3'b001) r1 = cyc;
        end
        checks++;
        if (r1 != rec + SS + STB - 1) begin
            failures++;
            $display("FAIL glitch_release got=%0d exp=%0d", r1, rec + SS + STB - 1);
        end
    endtask

    task automatic test_mask();
        por = 1; init = 1; cal = 4'b0111; mask = 4'b1000;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL mask_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (cdone !== 1'b1 || rout !== 3'b111) begin
            failures++;
            $display("FAIL mask_release got cdone=%b rout=%b exp 1/111", cdone, rout);
        end
    endtask

    task automatic test_timeout();
        por = 1; init = 1; cal = 4'b0111; mask = '0;
        do_reset();
        for (int i = 0; i < 230; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (tmo !== 1'b1 || rout !== 3'b000 || cdone !== 1'b0 || st !== 3'd5) begin
            failures++;
            $display("FAIL timeout_final got tmo=%b rout=%b cdone=%b st=%0d exp 1/000/0/5",
                     tmo, rout, cdone, st);
        end
    endtask

    task automatic test_por_drop();
        int n;
        por = 1; init = 1; cal = '1; mask = '0;
        do_reset();
        n = 0;
        while (!(ms == 3 && cyc - e_stg == 2) && n < 80) begin
            tick(); n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL pordrop_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (n >= 80) begin
            failures++;
            $display("FAIL pordrop_reach_stagger got=timeout exp=stagger");
        end
        por = 1'b0;
        repeat (SS) tick();
        checks++;
        if (st !== 3'd3 || rout !== 3'b001) begin
            failures++;
            $display("FAIL pordrop_early got st=%0d rout=%b exp 3/001", st, rout);
        end
        tick();
        checks++;
        if (st !== 3'd0 || rout !== 3'b000) begin
            failures++;
            $display("FAIL pordrop_idle got st=%0d rout=%b exp 0/000", st, rout);
        end
        for (int i = 0; i < 70; i++) begin
            if (i == 5) por = 1'b1;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL pordrop_restart cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_in_ready();
        por = 1; init = 1; cal = '1; mask = '0;
        do_reset();
        repeat (50) tick();
        checks++;
        if (cdone !== 1'b1 || st !== 3'd4) begin
            failures++;
            $display("FAIL rstready_pre got cdone=%b st=%0d exp 1/4", cdone, st);
        end
        rstn = 1'b0;
        tick();
        checks++;
        if (st !== 3'd0 || rout !== '0 || cdone !== 1'b0 || tmo !== 1'b0 || csync !== '0) begin
            failures++;
            $display("FAIL rstready_values got st=%0d rout=%b cdone=%b tmo=%b sync=%b exp all 0",
                     st, rout, cdone, tmo, csync);
        end
        rstn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rstready_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            mask = NB'($urandom);
            do_reset();
            for (int i = 0; i < 250; i++) begin
                por  = ($urandom_range(0, 299) != 0);
                init = ($urandom_range(0, 199) != 0);
                for (int b = 0; b < NB; b++) cal[b] = ($urandom_range(0, 199) != 0);
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
                end
            end
        end
    endtask

`ifdef INIT_MON_RECALIB_MONITOR_EN
    task automatic test_recalib();
        por = 1; init = 1; cal = '1; mask = '0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i == 50) cal[0] = 1'b0;
            if (i == 60) cal[0] = 1'b1;
            if (i == 70) cal[0] = 1'b0;
            if (i == 90) cal[0] = 1'b1;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL recalib_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (i == 69) begin
                checks++;
                if (st !== 3'd4 || recal !== 1'b0) begin
                    failures++;
                    $display("FAIL recalib_short got st=%0d ev=%b exp 4/0", st, recal);
                end
            end
            if (i == 89) begin
                checks++;
                if (st !== 3'd2 || rout !== 3'b000 || recal !== 1'b1 || cdone !== 1'b0) begin
                    failures++;
                    $display("FAIL recalib_long got st=%0d rout=%b ev=%b cdone=%b exp 2/000/1/0",
                             st, rout, recal, cdone);
                end
            end
        end
    endtask
`endif

    initial begin
        rstn = 1'b0; por = 1'b0; init = 1'b0; cal = '0; mask = '0;
        test_reset();
        test_nominal();
        test_glitch();
        test_mask();
        test_timeout();
        test_por_drop();
        test_reset_in_ready();
        test_random();
`ifdef INIT_MON_RECALIB_MONITOR_EN
        test_recalib();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
